// File: rtl/dla_window_gen_if.sv
// rtl/dla_window_gen_if.sv - handshake bundle between the ifm feeder, the window generator and the PE array
// Optional feature macro: DLA_WIN_PAD_EN (adds pad_en, sampled at start)
// Signals:
//   start, in_width, in_height [, pad_en] : channel configuration, start is a one-cycle pulse
//   in_valid, in_data, in_ready           : row-major pixel stream into the generator
//   stall                                 : PE pipeline stall
//   win_valid, win_data, out_row, out_col,
//   row_change, channel_done              : window stream towards the PE array
//   busy, cfg_err                         : status
interface dla_window_gen_if #(
  parameter int DATA_W = 8,
  parameter int DIM_W  = 7
);
  logic                  start;
  logic [DIM_W-1:0]      in_width;
  logic [DIM_W-1:0]      in_height;
`ifdef DLA_WIN_PAD_EN
  logic                  pad_en;
`endif
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_ready;
  logic                  stall;
  logic                  win_valid;
  logic [9*DATA_W-1:0]   win_data;
  logic [DIM_W-1:0]      out_row;
  logic [DIM_W-1:0]      out_col;
  logic                  row_change;
  logic                  channel_done;
  logic                  busy;
  logic                  cfg_err;

  modport master (
`ifdef DLA_WIN_PAD_EN
    output pad_en,
`endif
    output start, in_width, in_height, in_valid, in_data, stall,
    input  in_ready, win_valid, win_data, out_row, out_col,
    input  row_change, channel_done, busy, cfg_err
  );

  modport slave (
`ifdef DLA_WIN_PAD_EN
    input  pad_en,
`endif
    input  start, in_width, in_height, in_valid, in_data, stall,
    output in_ready, win_valid, win_data, out_row, out_col,
    output row_change, channel_done, busy, cfg_err
  );
endinterface

// File: rtl/dla_window_gen.sv
// rtl/dla_window_gen.sv - 3x3 convolution window generator with two line buffers
// Optional feature macro: DLA_WIN_PAD_EN (zero-padded "same" windows, pad_en input, FLUSH state)
// Ports:
//   clk         : clock
//   rst         : synchronous active-high reset
//   bus (slave) : configuration, pixel stream in, stall, window stream out, busy/cfg_err
module dla_window_gen #(
  parameter int MAX_W  = 64,
  parameter int DATA_W = 8,
  parameter int DIM_W  = 7
) (
  input logic             clk,
  input logic             rst,
  dla_window_gen_if.slave bus
);
  localparam int AW = $clog2(MAX_W);
  localparam logic [DIM_W:0] MAX_W_V = (DIM_W+1)'(MAX_W);

`ifdef DLA_WIN_PAD_EN
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DONE, S_FLUSH} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;
`endif

  state_t              state_q, state_d;
  logic [DIM_W-1:0]    x_q, y_q;
  // Last x/y step of the scan; padded mode scans one extra virtual column and row.
  logic [DIM_W-1:0]    lim_x_q, lim_y_q;
  logic [DATA_W-1:0]   lb0 [MAX_W];   // row y-1
  logic [DATA_W-1:0]   lb1 [MAX_W];   // row y-2
  logic [DATA_W-1:0]   col_a [3];     // column x-2, top to bottom
  logic [DATA_W-1:0]   col_b [3];     // column x-1
  logic [DATA_W-1:0]   new_col [3];   // column x
  logic [9*DATA_W-1:0] win_next;
  logic [AW-1:0]       idx;
  logic                pad_q, pad_sel, size_ok, cfg_ok;
  logic                in_ready_c, busy_c, vstep, accept, step;
  logic                vcol, wrap, last, emit, top_zero, left_zero;
  logic [DIM_W-1:0]    off;

  logic                win_valid_q, row_change_q, channel_done_q, cfg_err_q;
  logic [9*DATA_W-1:0] win_data_q;
  logic [DIM_W-1:0]    out_row_q, out_col_q;

`ifdef DLA_WIN_PAD_EN
  assign pad_sel = bus.pad_en;
  always_ff @(posedge clk) begin
    if (rst) pad_q <= 1'b0;
    else if (cfg_ok) pad_q <= bus.pad_en;
  end
`else
  assign pad_sel = 1'b0;
  assign pad_q   = 1'b0;
`endif

  assign size_ok = pad_sel ?
      (bus.in_width >= DIM_W'(2) && {1'b0, bus.in_width} <= MAX_W_V && bus.in_height >= DIM_W'(2)) :
      (bus.in_width >= DIM_W'(3) && {1'b0, bus.in_width} <= MAX_W_V && bus.in_height >= DIM_W'(3));
  assign cfg_ok  = (state_q == S_IDLE) && bus.start && size_ok;

  // The padded right column (x == W) is virtual: it consumes no input pixel.
  assign vcol      = pad_q && (x_q == lim_x_q);
  assign wrap      = (x_q == lim_x_q);
  assign last      = wrap && (y_q == lim_y_q);
  assign off       = pad_q ? DIM_W'(1) : DIM_W'(2);
  assign top_zero  = pad_q && (y_q == DIM_W'(1));
  assign left_zero = pad_q && (x_q == DIM_W'(1));
  assign idx       = x_q[AW-1:0];
  assign accept    = bus.in_valid && in_ready_c;
  assign step      = accept || vstep;
  assign emit      = step && (y_q >= off) && (x_q >= off);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    vstep      = 1'b0;
    busy_c     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (bus.start && size_ok) state_d = S_FILL;
      S_FILL, S_RUN: begin
        in_ready_c = !bus.stall && !vcol;
        vstep      = !bus.stall && vcol;
        if ((bus.in_valid && in_ready_c) || vstep) begin
          if (last) state_d = S_DONE;
          else if (wrap) begin
            if (y_q >= DIM_W'(1)) state_d = S_RUN;
`ifdef DLA_WIN_PAD_EN
            if (pad_q && (y_q + DIM_W'(1)) == lim_y_q) state_d = S_FLUSH;
`endif
          end
        end
      end
`ifdef DLA_WIN_PAD_EN
      S_FLUSH: begin
        vstep = !bus.stall;
        if (vstep && last) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // New column plus the two stored ones; the stored columns of a fresh row are stale,
  // but windows only use them once they hold the current row (or are zero-masked).
  always_comb begin
    new_col[0] = vcol  ? '0 : lb1[idx];
    new_col[1] = vcol  ? '0 : lb0[idx];
    new_col[2] = vstep ? '0 : bus.in_data;
    win_next   = '0;
    for (int r = 0; r < 3; r++) begin
      if (!(r == 0 && top_zero)) begin
        if (!left_zero) win_next[DATA_W*(3*r) +: DATA_W] = col_a[r];
        win_next[DATA_W*(3*r+1) +: DATA_W] = col_b[r];
        win_next[DATA_W*(3*r+2) +: DATA_W] = new_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[idx] <= lb0[idx];
      lb0[idx] <= bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q            <= '0;
      y_q            <= '0;
      lim_x_q        <= '0;
      lim_y_q        <= '0;
      for (int r = 0; r < 3; r++) begin
        col_a[r] <= '0;
        col_b[r] <= '0;
      end
      win_valid_q    <= 1'b0;
      win_data_q     <= '0;
      out_row_q      <= '0;
      out_col_q      <= '0;
      row_change_q   <= 1'b0;
      channel_done_q <= 1'b0;
      cfg_err_q      <= 1'b0;
    end else begin
      cfg_err_q <= (state_q == S_IDLE) && bus.start && !size_ok;
      if (cfg_ok) begin
        x_q     <= '0;
        y_q     <= '0;
        lim_x_q <= pad_sel ? bus.in_width  : bus.in_width  - DIM_W'(1);
        lim_y_q <= pad_sel ? bus.in_height : bus.in_height - DIM_W'(1);
      end else if (step) begin
        for (int r = 0; r < 3; r++) begin
          col_a[r] <= col_b[r];
          col_b[r] <= new_col[r];
        end
        if (wrap) begin
          x_q <= '0;
          y_q <= y_q + DIM_W'(1);
        end else begin
          x_q <= x_q + DIM_W'(1);
        end
      end
      // Outputs freeze under stall; a new window can only appear when not stalled.
      if (!bus.stall) begin
        win_valid_q    <= emit;
        row_change_q   <= emit && (x_q == off) && (y_q != off);
        channel_done_q <= emit && last;
        if (emit) begin
          win_data_q <= win_next;
          out_row_q  <= y_q - off;
          out_col_q  <= x_q - off;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.busy         = busy_c;
  assign bus.cfg_err      = cfg_err_q;
  assign bus.win_valid    = win_valid_q;
  assign bus.win_data     = win_data_q;
  assign bus.out_row      = out_row_q;
  assign bus.out_col      = out_col_q;
  assign bus.row_change   = row_change_q;
  assign bus.channel_done = channel_done_q;
endmodule

// File: tb/tb_dla_window_gen.sv
// tb/tb_dla_window_gen.sv - self-checking bench for dla_window_gen
module tb_dla_window_gen;
  localparam int DATA_W = 8;
  localparam int DIM_W  = 7;
  localparam int MAX_W  = 64;

  typedef struct {
    logic [71:0] data;
    int          row;
    int          col;
    logic        rc;
    logic        done;
  } win_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dla_window_gen_if #(.DATA_W(DATA_W), .DIM_W(DIM_W)) bus ();
  dla_window_gen #(.MAX_W(MAX_W), .DATA_W(DATA_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int          errors = 0;
  int          checks = 0;
  win_t        exp_q[$];
  logic [7:0]  img [256];
  int          cur_w, cur_h;
  int          n_seen;
  logic [71:0] first_dut, last_dut;
  logic        last_ready;
  logic        prev_hold = 1'b0;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pix(int r, int c);
    if (r < 0 || c < 0 || r >= cur_h || c >= cur_w) return 8'h00;
    return img[r*cur_w + c];
  endfunction

  // Reference: every output position gets the 3x3 neighbourhood read straight from the image.
  task automatic prep(int w, int h, bit pad);
    int ofs = pad ? 1 : 0;
    int nr  = pad ? h : h - 2;
    int nc  = pad ? w : w - 2;
    win_t e;
    cur_w = w; cur_h = h;
    for (int i = 0; i < w*h; i++) img[i] = 8'(i);
    exp_q.delete();
    n_seen = 0; first_dut = '0; last_dut = '0; last_ready = 1'b1;
    for (int r = 0; r < nr; r++)
      for (int c = 0; c < nc; c++) begin
        e.data = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.data[8*(3*i+j) +: 8] = pix(r + i - ofs, c + j - ofs);
        e.row = r; e.col = c;
        e.rc = (c == 0 && r != 0);
        e.done = (r == nr-1 && c == nc-1);
        exp_q.push_back(e);
      end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_hold) chk("hold_valid", 72'(bus.win_valid), 72'(1));
      if (bus.stall) chk("in_ready_stall", 72'(bus.in_ready), 72'(0));
      if (bus.win_valid) begin
        if (exp_q.size() == 0) chk("extra_window", 72'(bus.win_valid), 72'(0));
        else begin
          chk("win_data", bus.win_data, exp_q[0].data);
          chk("out_row", 72'(bus.out_row), 72'(exp_q[0].row));
          chk("out_col", 72'(bus.out_col), 72'(exp_q[0].col));
          chk("row_change", 72'(bus.row_change), 72'(exp_q[0].rc));
          chk("channel_done", 72'(bus.channel_done), 72'(exp_q[0].done));
          if (!bus.stall) begin
            if (n_seen == 0) first_dut = bus.win_data;
            if (bus.channel_done) begin
              last_dut = bus.win_data;
              last_ready = bus.in_ready;
            end
            n_seen++;
            void'(exp_q.pop_front());
          end
        end
      end
      prev_hold = bus.win_valid && bus.stall;
    end else begin
      prev_hold = 1'b0;
    end
  end

  task automatic drive(int w, int h, bit pad, bit bubble, int stall_pix, int stall_len, int stop_after);
    int   idx = 0;
    int   cyc = 0;
    logic tog = 1'b1;
    logic acc;
    bus.in_width  = DIM_W'(w);
    bus.in_height = DIM_W'(h);
`ifdef DLA_WIN_PAD_EN
    bus.pad_en = pad;
`endif
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    while (idx < stop_after && cyc < 2000) begin
      bus.in_valid = bubble ? tog : 1'b1;
      bus.in_data  = img[idx];
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      cyc++;
      tog = ~tog;
      if (acc) begin
        if (idx == stall_pix) begin
          bus.stall = 1'b1;
          repeat (stall_len) begin @(posedge clk); #1; end
          bus.stall = 1'b0;
        end
        idx++;
      end
    end
    bus.in_valid = 1'b0;
    chk("pixels_accepted", 72'(idx), 72'(stop_after));
  endtask

  task automatic finish_run(int n_exp);
    for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.busy); i++) @(negedge clk);
    chk("windows_left", 72'(exp_q.size()), 72'(0));
    chk("windows_seen", 72'(n_seen), 72'(n_exp));
    chk("busy_end", 72'(bus.busy), 72'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.in_width = '0; bus.in_height = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.stall = 1'b0;
`ifdef DLA_WIN_PAD_EN
    bus.pad_en = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_win_valid", 72'(bus.win_valid), 72'(0));
    chk("rst_win_data", bus.win_data, 72'(0));
    chk("rst_busy", 72'(bus.busy), 72'(0));
    chk("rst_in_ready", 72'(bus.in_ready), 72'(0));
    chk("rst_cfg_err", 72'(bus.cfg_err), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: plain 4x4
    prep(4, 4, 1'b0);
    chk("model_first", exp_q[0].data, 72'h0a_09_08_06_05_04_02_01_00);
    chk("model_last", exp_q[3].data, 72'h0f_0e_0d_0b_0a_09_07_06_05);
    chk("model_rc", 72'(exp_q[2].rc), 72'(1));
    drive(4, 4, 1'b0, 1'b0, -1, 0, 16);
    finish_run(4);
    chk("t1_first", first_dut, 72'h0a_09_08_06_05_04_02_01_00);
    chk("t1_last", last_dut, 72'h0f_0e_0d_0b_0a_09_07_06_05);
    chk("t1_last_ready", 72'(last_ready), 72'(0));

    // 2: stall for 3 cycles while window (0,1) is presented (pixel 11 creates it)
    prep(4, 4, 1'b0);
    drive(4, 4, 1'b0, 1'b0, 11, 3, 16);
    finish_run(4);
    chk("t2_last", last_dut, 72'h0f_0e_0d_0b_0a_09_07_06_05);

    // 3: 5x3 with in_valid bubbles
    prep(5, 3, 1'b0);
    chk("model_5x3_first", exp_q[0].data, 72'h0c_0b_0a_07_06_05_02_01_00);
    drive(5, 3, 1'b0, 1'b1, -1, 0, 15);
    finish_run(3);
    chk("t3_first", first_dut, 72'h0c_0b_0a_07_06_05_02_01_00);

    // 4: illegal width, then reset in the middle of a channel
    bus.in_width = DIM_W'(2); bus.in_height = DIM_W'(4); bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", 72'(bus.cfg_err), 72'(1));
    chk("cfg_err_busy", 72'(bus.busy), 72'(0));
    @(negedge clk);
    chk("cfg_err_once", 72'(bus.cfg_err), 72'(0));
    @(posedge clk); #1;
    exp_q.delete();
    drive(4, 4, 1'b0, 1'b0, -1, 0, 8);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 72'(bus.busy), 72'(0));
    chk("abort_in_ready", 72'(bus.in_ready), 72'(0));
    chk("abort_win_valid", 72'(bus.win_valid), 72'(0));
    chk("abort_win_data", bus.win_data, 72'(0));
    chk("abort_row_col", 72'({bus.out_row, bus.out_col}), 72'(0));
    chk("abort_flags", 72'({bus.row_change, bus.channel_done, bus.cfg_err}), 72'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    prep(4, 4, 1'b0);
    drive(4, 4, 1'b0, 1'b0, -1, 0, 16);
    finish_run(4);
    chk("t4_first", first_dut, 72'h0a_09_08_06_05_04_02_01_00);

`ifdef DLA_WIN_PAD_EN
    // 5: zero-padded 3x3
    prep(3, 3, 1'b1);
    chk("model_pad_first", exp_q[0].data, 72'h04_03_00_01_00_00_00_00_00);
    chk("model_pad_last", exp_q[8].data, 72'h00_00_00_00_08_07_00_05_04);
    drive(3, 3, 1'b1, 1'b0, -1, 0, 9);
    finish_run(9);
    chk("t5_first", first_dut, 72'h04_03_00_01_00_00_00_00_00);
    chk("t5_last", last_dut, 72'h00_00_00_00_08_07_00_05_04);
    chk("t5_last_ready", 72'(last_ready), 72'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dla_window_gen.md
Name: dla_window_gen

Overview:
Upstream feeder of the DLA PE array. Accepts a row-major stream of 8-bit ifm pixels for one channel and keeps two line buffers plus a 3x3 shift window. Emits one 9-byte convolution window per output position, in the PE's MAC lane order, together with row/channel markers. It honours the PE pipeline stall so no window is lost or duplicated.

Parameters:
MAX_W, 64, maximum ifm width in pixels (line buffer depth)
DATA_W, 8, pixel width (BYTE)
DIM_W, 7, width of the size and coordinate fields

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
start  in  1  pulse; latches in_width/in_height and begins a channel
in_width  in  DIM_W  ifm width W, valid range 3..MAX_W
in_height  in  DIM_W  ifm height H, valid range >=3
in_valid  in  1  in_data valid
in_data  in  DATA_W  pixel
in_ready  out  1  pixel accepted when in_valid&in_ready
stall  in  1  PE stall; freezes window outputs
win_valid  out  1  win_data holds a new window
win_data  out  9*DATA_W  element k=3*r+c at bits [8k+7:8k]; r=0 is the top row, c=0 the left column
out_row  out  DIM_W  output row of the current window
out_col  out  DIM_W  output column of the current window
row_change  out  1  high with the first window of each output row except row 0
channel_done  out  1  high with the last window of the channel
busy  out  1  state != IDLE
cfg_err  out  1  one-cycle pulse on an illegal start

Behaviour:
- Reset: state=IDLE; all outputs 0; column/row counters and window registers cleared. Line buffer contents are don't-care. Reset mid-channel aborts immediately; no further windows are emitted.
- States:
  - IDLE: start with 3<=W<=MAX_W and H>=3 -> FILL. Any other start -> cfg_err=1 for one cycle, stay IDLE.
  - FILL: accepting rows 0..1.
  - RUN: row >= 2.
  - FLUSH: PAD_EN only.
  - DONE: one cycle, then IDLE.
- start while busy: ignored, no cfg_err.
- in_ready = (FILL|RUN) & !stall.
- On each accepted pixel at input (y,x):
  - Write the pixel into the line buffers.
  - Shift the 3-column window left; the new column is {linebuf1[x], linebuf0[x], in_data}.
  - Advance x; at x=W-1, wrap x to 0 and increment y.
- Window rule (no pad): when y>=2 and x>=2, register the window at out (y-2, x-2). win_valid=1 in the next cycle, so latency is 1 clk from acceptance.
- Each window is a fresh 3x3. The horizontal shift registers restart at x=0, so no wrap-around mixing across rows.
- Output count: (H-2)*(W-2) windows per channel.
- Stall: while stall=1, win_valid, win_data, out_row/out_col, row_change and channel_done hold their values. No new input is accepted.
- Each window is presented with win_valid=1 for exactly one non-stalled cycle; win_valid then drops unless a new window arrives.
- channel_done coincides with the last window. The FSM then enters DONE, drops busy and returns to IDLE. Accepting the final pixel ends input (in_ready=0).
- in_valid=0 bubbles: no state change and no window.
- Arithmetic: no arithmetic on pixel data. Counters saturate nowhere; they compare against the latched W-1/H-1.

Optional Feature:
DLA_WIN_PAD_EN
- With the macro: adds input port pad_en (1 bit, sampled at start).
  - pad_en=1: zero-padded "same" convolution with H*W windows, out (r,c) centred on pixel (r,c).
  - Window out (r,c) is emitted once pixel (r+1,c+1) has been accepted.
  - Edge positions are substituted with 0.
  - After the last input pixel, the FSM enters FLUSH with in_ready=0 and emits the remaining last-row/last-column windows internally, one per non-stalled cycle.
  - Accepted start sizes: W>=2, H>=2.
  - pad_en=0: identical to the behaviour without the macro.
- Without the macro: no pad_en port, no FLUSH state, and only the valid-convolution behaviour above.

Test Plan:
1. 4x4 image, pixels 0..15, in_valid=1 constantly, stall=0 -> exactly 4 windows; first win_data = {0,1,2,4,5,6,8,9,10} (k=0..8); window (1,0) has row_change=1; last window {5,6,7,9,10,11,13,14,15} has channel_done=1; then busy=0.
2. Same image with stall=1 for 3 cycles when window (0,1) is presented -> win_data/win_valid are held for those 3 cycles; in_ready=0; the sequence is unchanged and no window is duplicated or lost.
3. 5x3 image with in_valid toggling 1,0,1,0 -> 3 windows identical to the bubble-free run; win_valid never asserts during a bubble.
4. start with in_width=2 -> cfg_err pulses once, busy stays 0. Then start with W=4, H=4 and reset asserted after 8 pixels -> all outputs 0 next cycle, and a subsequent valid start produces correct windows.
5. DLA_WIN_PAD_EN defined, pad_en=1, 3x3 image 0..8 -> 9 windows; first = {0,0,0,0,0,1,0,3,4}; last = {4,5,0,7,8,0,0,0,0} with channel_done=1, emitted during FLUSH with in_ready=0.
